// File: rtl/vetris_pkg.sv
// Shared definitions for the CPU <-> board row link: FSM state encoding and row geometry.
package vetris_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } row_state_e;

  localparam int ROW_BEATS  = 4;
  localparam int ROW_BYTE_W = 8;
  localparam int ROW_W      = ROW_BEATS * ROW_BYTE_W;
endpackage

// File: rtl/row_link_if.sv
// Byte-wide board bus carrying one row as ROW_BEATS request/ack beats.
interface row_link_if;
  import vetris_pkg::*;
  logic                  brd_req;
  logic                  brd_we;
  logic [4:0]            brd_addr;
  logic [1:0]            brd_beat;
  logic [ROW_BYTE_W-1:0] brd_wdata;
  logic                  brd_ack;
  logic [ROW_BYTE_W-1:0] brd_rdata;

  modport master (output brd_req, brd_we, brd_addr, brd_beat, brd_wdata,
                  input  brd_ack, brd_rdata);
  modport slave  (input  brd_req, brd_we, brd_addr, brd_beat, brd_wdata,
                  output brd_ack, brd_rdata);
endinterface

// File: rtl/row_link_wdog.sv
// Per-beat watchdog: counts XFER cycles without ack, restarting on every new beat.
module row_link_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  input  logic i_ack,
  output logic o_expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  assign o_expired = i_run && !i_ack && (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_cnt <= '0;
    else if (!i_run || i_ack || o_expired) r_cnt <= '0;
    else                                  r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/row_link.sv
// Moves a 32-bit row word between CPU and board as four byte beats, stalling the pipeline meanwhile.
// Optional per-beat timeout enabled by defining ROW_LINK_TIMEOUT_EN.
module row_link
  import vetris_pkg::*;
#(
  parameter int NUM_ROWS = 20,
  parameter int TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             send_row,
  input  logic             get_row,
  input  logic [4:0]       row_idx,
  input  logic [ROW_W-1:0] wdata,
  output logic             stall,
  output logic [ROW_W-1:0] rdata,
  output logic             rdata_vld,
  output logic             err,
  row_link_if.master       brd
);
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] XFER = ST_XFER;
  localparam logic [1:0] DONE = ST_DONE;

  logic [1:0]       r_state;
  logic             r_we;
  logic [4:0]       r_addr;
  logic [1:0]       r_beat;
  logic [ROW_W-1:0] r_wdata;
  logic [ROW_W-1:0] r_rdata;
  logic             r_err;

  logic w_start, w_oor, w_last, w_tmo;

  assign w_start = (r_state == IDLE) && (send_row || get_row);
  assign w_oor   = {27'd0, row_idx} >= 32'(NUM_ROWS);
  assign w_last  = r_beat == 2'(ROW_BEATS - 1);

`ifdef ROW_LINK_TIMEOUT_EN
  row_link_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_run     (r_state == XFER),
    .i_ack     (brd.brd_ack),
    .o_expired (w_tmo)
  );
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT > 0);
  assign w_tmo        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_beat  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_start) begin
          // send_row has priority when both instructions arrive together
          r_we    <= send_row;
          r_addr  <= row_idx;
          r_wdata <= wdata;
          r_beat  <= '0;
          if (!send_row) r_rdata <= '0;
          if (w_oor) begin
            r_err   <= 1'b1;
            r_state <= DONE;
          end else begin
            r_state <= XFER;
          end
        end
        XFER: if (brd.brd_ack) begin
          if (!r_we) r_rdata[{r_beat, 3'b000} +: ROW_BYTE_W] <= brd.brd_rdata;
          if (w_last) r_state <= DONE;
          else        r_beat  <= r_beat + 2'd1;
        end else if (w_tmo) begin
          // a timed-out read must not expose the partially assembled word
          if (!r_we) r_rdata <= '0;
          r_err   <= 1'b1;
          r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stall         = w_start || (r_state == XFER);
  assign rdata         = r_rdata;
  assign rdata_vld     = (r_state == DONE) && !r_we;
  assign err           = r_err;
  assign brd.brd_req   = (r_state == XFER);
  assign brd.brd_we    = r_we;
  assign brd.brd_addr  = r_addr;
  assign brd.brd_beat  = r_beat;
  assign brd.brd_wdata = r_wdata[{r_beat, 3'b000} +: ROW_BYTE_W];
endmodule

// File: tb/tb_row_link.sv
// Bench for row_link: transaction-level model checked every cycle, directed literal cases, then random traffic.
module tb_row_link;
  localparam int NR  = 20;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        send_row, get_row;
  logic [4:0]  row_idx;
  logic [31:0] wdata;
  logic        stall, rdata_vld, err;
  logic [31:0] rdata;

  row_link_if brd ();

  row_link #(.NUM_ROWS(NR), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .send_row(send_row), .get_row(get_row),
    .row_idx(row_idx), .wdata(wdata), .stall(stall), .rdata(rdata),
    .rdata_vld(rdata_vld), .err(err), .brd(brd)
  );

  always #5 clk = ~clk;

  // Model: beats still owed by the board, a one-cycle completion slot, and the architectural results.
  int          m_left, m_wait;
  bit          m_done, m_rd, m_err;
  logic [4:0]  m_addr;
  logic [31:0] m_word, m_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0; m_wait <= 0; m_done <= 0; m_rd <= 0; m_err <= 0;
      m_addr <= '0; m_word <= '0; m_rdata <= '0;
    end else if (m_done) begin
      m_done <= 0;
    end else if (m_left == 0) begin
      if (send_row || get_row) begin
        m_rd <= !send_row; m_addr <= row_idx; m_word <= wdata; m_wait <= 0;
        if (!send_row) m_rdata <= '0;
        if (int'(row_idx) >= NR) begin m_err <= 1; m_done <= 1; end
        else m_left <= 4;
      end
    end else if (brd.brd_ack) begin
      if (m_rd) m_rdata[8*(4-m_left) +: 8] <= brd.brd_rdata;
      m_left <= m_left - 1; m_wait <= 0;
      if (m_left == 1) m_done <= 1;
    end
`ifdef ROW_LINK_TIMEOUT_EN
    else if (m_wait == TMO - 1) begin
      m_left <= 0; m_done <= 1; m_err <= 1;
      if (m_rd) m_rdata <= '0;
    end
`endif
    else m_wait <= m_wait + 1;
  end

  int n_chk = 0, n_err = 0;
  int ack_mode, wcnt;
  int stall_cnt, req_cnt, vld_cnt, we_beats, rd_beats, vld_stall;
  logic [7:0]  wlog [4];
  logic [4:0]  last_addr;
  logic [31:0] last_vld;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic clr();
    stall_cnt = 0; req_cnt = 0; vld_cnt = 0; we_beats = 0; rd_beats = 0; vld_stall = 0;
    last_addr = '0; last_vld = 'x;
    for (int i = 0; i < 4; i++) wlog[i] = 'x;
  endtask

  task automatic compare();
    int b;
    b = 4 - m_left;
    chk("stall", stall, (m_left != 0) || (!m_done && m_left == 0 && (send_row || get_row)));
    chk("brd_req", brd.brd_req, m_left != 0);
    if (m_left != 0) begin
      chk("brd_we", brd.brd_we, !m_rd);
      chk("brd_addr", brd.brd_addr, m_addr);
      chk("brd_beat", brd.brd_beat, b);
      chk("brd_wdata", brd.brd_wdata, 8'(m_word >> (8*b)));
    end
    chk("rdata", rdata, m_rdata);
    chk("rdata_vld", rdata_vld, m_done && m_rd);
    chk("err", err, m_err);
  endtask

  task automatic drive_ack();
    case (ack_mode)
      1: brd.brd_ack = 1'b1;
      2: begin
        if (brd.brd_req) begin
          if (wcnt == 2) begin brd.brd_ack = 1'b1; wcnt = 0; end
          else begin brd.brd_ack = 1'b0; wcnt++; end
        end else begin brd.brd_ack = 1'b0; wcnt = 0; end
      end
      3: brd.brd_ack = 1'b0;
      default: brd.brd_ack = ($urandom_range(0, 3) != 0);
    endcase
    if (ack_mode == 0) brd.brd_rdata = 8'($urandom);
    else brd.brd_rdata = 8'(8'h11 * (int'(brd.brd_beat) + 1));
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    if (stall) stall_cnt++;
    if (brd.brd_req) req_cnt++;
    if (brd.brd_req && brd.brd_ack && brd.brd_we) begin
      wlog[brd.brd_beat] = brd.brd_wdata; we_beats++; last_addr = brd.brd_addr;
    end
    if (brd.brd_req && brd.brd_ack && !brd.brd_we) rd_beats++;
    if (rdata_vld) begin vld_cnt++; last_vld = rdata; if (stall) vld_stall++; end
    @(posedge clk); #1;
    drive_ack();
  endtask

  task automatic issue(input bit s, input bit g, input logic [4:0] idx, input logic [31:0] d, input int n);
    send_row = s; get_row = g; row_idx = idx; wdata = d;
    cycle();
    send_row = 0; get_row = 0;
    repeat (n) cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; send_row = 0; get_row = 0; row_idx = '0; wdata = '0;
    brd.brd_ack = 0; brd.brd_rdata = '0; ack_mode = 1; wcnt = 0;
    clr();
    repeat (2) @(negedge clk);
    chk("rst_brd_req", brd.brd_req, 0);
    chk("rst_brd_we", brd.brd_we, 0);
    chk("rst_brd_addr", brd.brd_addr, 0);
    chk("rst_brd_beat", brd.brd_beat, 0);
    chk("rst_brd_wdata", brd.brd_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rdata_vld", rdata_vld, 0);
    chk("rst_err", err, 0);
    send_row = 1; #1;
    chk("rst_stall_comb", stall, 1);
    send_row = 0;
    @(posedge clk); #1;
    rst_n = 1;
    cycle();

    // send row 3, zero-wait board
    clr(); ack_mode = 1;
    issue(1, 0, 5'd3, 32'hDEADBEEF, 7);
    chk("w_b0", wlog[0], 8'hEF);
    chk("w_b1", wlog[1], 8'hBE);
    chk("w_b2", wlog[2], 8'hAD);
    chk("w_b3", wlog[3], 8'hDE);
    chk("w_addr", last_addr, 3);
    chk("w_stall_cyc", stall_cnt, 5);
    chk("w_no_vld", vld_cnt, 0);

    // get row 19, board acks two cycles late
    clr(); ack_mode = 2;
    issue(0, 1, 5'd19, 32'h0, 20);
    chk("r_beats", rd_beats, 4);
    chk("r_vld_cnt", vld_cnt, 1);
    chk("r_vld_data", last_vld, 32'h44332211);
    chk("r_vld_stall", vld_stall, 0);

    // both instructions: write wins
    clr(); ack_mode = 1;
    issue(1, 1, 5'd7, 32'h000003FF, 7);
    chk("both_we_beats", we_beats, 4);
    chk("both_rd_beats", rd_beats, 0);
    chk("both_b0", wlog[0], 8'hFF);
    chk("both_b1", wlog[1], 8'h03);
    chk("both_no_vld", vld_cnt, 0);
    chk("both_rdata_hold", rdata, 32'h44332211);
    chk("err_clean", err, 0);

    // out-of-range read
    clr();
    issue(0, 1, 5'd20, 32'h0, 4);
    chk("oor_no_req", req_cnt, 0);
    chk("oor_err", err, 1);
    chk("oor_vld_cnt", vld_cnt, 1);
    chk("oor_rdata", last_vld, 0);

    // reset during beat 2 of a read
    clr(); ack_mode = 2;
    issue(0, 1, 5'd9, 32'h0, 0);
    for (int k = 0; k < 40 && brd.brd_beat != 2'd2; k++) cycle();
    chk("mid_reach_beat2", brd.brd_beat, 2);
    rst_n = 0; #1;
    chk("mid_req_drop", brd.brd_req, 0);
    chk("mid_beat_clr", brd.brd_beat, 0);
    chk("mid_err_clr", err, 0);
    chk("mid_rdata_clr", rdata, 0);
    cycle(); cycle();
    rst_n = 1;
    clr();
    repeat (5) cycle();
    chk("mid_no_vld", vld_cnt, 0);
    chk("mid_no_req", req_cnt, 0);
    clr();
    issue(0, 1, 5'd9, 32'h0, 20);
    chk("mid_next_vld", vld_cnt, 1);
    chk("mid_next_data", last_vld, 32'h44332211);

`ifdef ROW_LINK_TIMEOUT_EN
    clr(); ack_mode = 3;
    issue(0, 1, 5'd5, 32'h0, 12);
    chk("tmo_xfer_cyc", req_cnt, TMO);
    chk("tmo_err", err, 1);
    chk("tmo_vld_cnt", vld_cnt, 1);
    chk("tmo_rdata", last_vld, 0);
`endif

    // random traffic, including out-of-range rows and stray acks
    ack_mode = 0;
    for (int c = 0; c < 3000; c++) begin
      send_row = ($urandom_range(0, 5) == 0);
      get_row  = ($urandom_range(0, 5) == 0);
      row_idx  = ($urandom_range(0, 11) == 0) ? 5'($urandom_range(20, 31)) : 5'($urandom_range(0, 19));
      wdata    = $urandom;
      cycle();
    end
    send_row = 0; get_row = 0;
    repeat (10) cycle();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
